// File: rtl/dma_frame_sequencer.sv
// dma_frame_sequencer: ping-pong frame-buffer controller for the read DMA.
// It programs the DMA control slave over Avalon-MM and swaps the read buffer
// at a frame end once the writer has finished a newer frame.
// Optional build macro: SEQ_FRAME_TIMEOUT_EN adds a watchdog that restarts
// the DMA when no frame end is seen for TIMEOUT_CYCLES cycles in RUN.
module dma_frame_sequencer #(
    parameter int          ADDR_WIDTH     = 24,
    parameter int          CNT_WIDTH      = 16,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [ADDR_WIDTH-1:0] cfg_buf0_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_buf1_addr,
    input  logic [29:0]           cfg_frame_words,
    input  logic                  wr_frame_done,
    output logic                  wr_buf_sel,
    output logic                  wr_buf_ready,
    output logic                  rd_buf_sel,
    input  logic                  st_valid,
    input  logic                  st_ready,
    input  logic                  st_endofpacket,
    output logic [3:0]            mm_address,
    output logic                  mm_write,
    output logic [31:0]           mm_writedata,
    output logic [3:0]            mm_byteenable,
    input  logic                  mm_waitrequest,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_shown,
    output logic                  err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_WORDS = 3'd1,
        S_WR_ADDR  = 3'd2,
        S_WR_EN    = 3'd3,
        S_RUN      = 3'd4,
        S_WR_DIS   = 3'd5
    } state_t;

    localparam logic [3:0] REG_ADDR  = 4'h0;
    localparam logic [3:0] REG_WORDS = 4'h4;
    localparam logic [3:0] REG_EN    = 4'h8;

    state_t state_r;
    logic   pending_r;
    logic   dma_en_r;

    logic frame_end_s;
    logic write_done_s;
    logic timeout_hit_s;

    // Zero-extended byte base address of the selected buffer.
    function automatic logic [31:0] base_word(input logic sel,
                                              input logic [ADDR_WIDTH-1:0] b0,
                                              input logic [ADDR_WIDTH-1:0] b1);
        logic [31:0] w;
        w = 32'd0;
        if (sel) begin
            w[ADDR_WIDTH-1:0] = b1;
        end else begin
            w[ADDR_WIDTH-1:0] = b0;
        end
        return w;
    endfunction

    assign frame_end_s   = st_valid && st_ready && st_endofpacket && (state_r == S_RUN);
    assign write_done_s  = mm_write && !mm_waitrequest;
    assign mm_byteenable = 4'hF;

`ifdef SEQ_FRAME_TIMEOUT_EN
    logic [23:0] wdog_r;

    assign timeout_hit_s = (state_r == S_RUN) && cfg_enable && !frame_end_s &&
                           (wdog_r == (TIMEOUT_CYCLES - 24'd1));

    // Watchdog: counts RUN cycles, cleared by frame end, timeout or leaving RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= 24'd0;
        end else if ((state_r == S_RUN) && !frame_end_s && !timeout_hit_s) begin
            wdog_r <= wdog_r + 24'd1;
        end else begin
            wdog_r <= 24'd0;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_hit_s    = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign err_timeout      = 1'b0;
`endif

    // Sequencer FSM: programs the DMA, tracks the writer handshake, swaps buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            pending_r    <= 1'b0;
            dma_en_r     <= 1'b0;
            rd_buf_sel   <= 1'b0;
            wr_buf_sel   <= 1'b1;
            wr_buf_ready <= 1'b1;
            mm_address   <= 4'h0;
            mm_write     <= 1'b0;
            mm_writedata <= 32'd0;
            busy         <= 1'b0;
            frames_shown <= '0;
`ifdef SEQ_FRAME_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
        end else begin
`ifdef SEQ_FRAME_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            // A second completed frame while one is pending is dropped.
            if (wr_frame_done && !pending_r) begin
                pending_r    <= 1'b1;
                wr_buf_ready <= 1'b0;
            end

            case (state_r)
                S_IDLE: begin
                    if (cfg_enable) begin
                        state_r <= S_WR_WORDS;
                        busy    <= 1'b1;
                    end
                end

                S_WR_WORDS: begin
                    if (!mm_write) begin
                        mm_write     <= 1'b1;
                        mm_address   <= REG_WORDS;
                        mm_writedata <= {2'b00, cfg_frame_words};
                    end else if (write_done_s) begin
                        if (!cfg_enable) begin
                            state_r      <= S_WR_DIS;
                            mm_address   <= REG_EN;
                            mm_writedata <= 32'd0;
                        end else begin
                            state_r      <= S_WR_ADDR;
                            mm_address   <= REG_ADDR;
                            mm_writedata <= base_word(rd_buf_sel, cfg_buf0_addr, cfg_buf1_addr);
                        end
                    end
                end

                S_WR_ADDR: begin
                    if (write_done_s) begin
                        if (!cfg_enable) begin
                            state_r      <= S_WR_DIS;
                            mm_address   <= REG_EN;
                            mm_writedata <= 32'd0;
                        end else if (!dma_en_r) begin
                            state_r      <= S_WR_EN;
                            mm_address   <= REG_EN;
                            mm_writedata <= 32'd1;
                        end else begin
                            state_r  <= S_RUN;
                            mm_write <= 1'b0;
                        end
                    end
                end

                S_WR_EN: begin
                    if (write_done_s) begin
                        dma_en_r <= 1'b1;
                        if (!cfg_enable) begin
                            state_r      <= S_WR_DIS;
                            mm_address   <= REG_EN;
                            mm_writedata <= 32'd0;
                        end else begin
                            state_r  <= S_RUN;
                            mm_write <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
                    if (frame_end_s) begin
                        frames_shown <= frames_shown + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (!cfg_enable) begin
                        state_r      <= S_WR_DIS;
                        mm_write     <= 1'b1;
                        mm_address   <= REG_EN;
                        mm_writedata <= 32'd0;
                    end else if (frame_end_s && (pending_r || wr_frame_done)) begin
                        // A same-cycle wr_frame_done counts as pending here.
                        state_r      <= S_WR_ADDR;
                        rd_buf_sel   <= ~rd_buf_sel;
                        wr_buf_sel   <= rd_buf_sel;
                        pending_r    <= 1'b0;
                        wr_buf_ready <= 1'b1;
                        mm_write     <= 1'b1;
                        mm_address   <= REG_ADDR;
                        mm_writedata <= base_word(~rd_buf_sel, cfg_buf0_addr, cfg_buf1_addr);
                    end else if (timeout_hit_s) begin
`ifdef SEQ_FRAME_TIMEOUT_EN
                        err_timeout  <= 1'b1;
`endif
                        state_r      <= S_WR_ADDR;
                        mm_write     <= 1'b1;
                        mm_address   <= REG_ADDR;
                        mm_writedata <= base_word(rd_buf_sel, cfg_buf0_addr, cfg_buf1_addr);
                    end else begin
                        state_r <= S_RUN;
                    end
                end

                S_WR_DIS: begin
                    if (write_done_s) begin
                        dma_en_r <= 1'b0;
                        mm_write <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end
                end

                default: begin
                    state_r  <= S_IDLE;
                    mm_write <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_frame_sequencer.sv
// Directed, table-driven bench for dma_frame_sequencer.
module tb_dma_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic [23:0] cfg_buf0_addr;
    logic [23:0] cfg_buf1_addr;
    logic [29:0] cfg_frame_words;
    logic        wr_frame_done;
    logic        wr_buf_sel;
    logic        wr_buf_ready;
    logic        rd_buf_sel;
    logic        st_valid, st_ready, st_endofpacket;
    logic [3:0]  mm_address;
    logic        mm_write;
    logic [31:0] mm_writedata;
    logic [3:0]  mm_byteenable;
    logic        mm_waitrequest;
    logic        busy;
    logic [15:0] frames_shown;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    dma_frame_sequencer #(
        .ADDR_WIDTH    (24),
        .CNT_WIDTH     (16),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_enable     (cfg_enable),
        .cfg_buf0_addr  (cfg_buf0_addr),
        .cfg_buf1_addr  (cfg_buf1_addr),
        .cfg_frame_words(cfg_frame_words),
        .wr_frame_done  (wr_frame_done),
        .wr_buf_sel     (wr_buf_sel),
        .wr_buf_ready   (wr_buf_ready),
        .rd_buf_sel     (rd_buf_sel),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_endofpacket (st_endofpacket),
        .mm_address     (mm_address),
        .mm_write       (mm_write),
        .mm_writedata   (mm_writedata),
        .mm_byteenable  (mm_byteenable),
        .mm_waitrequest (mm_waitrequest),
        .busy           (busy),
        .frames_shown   (frames_shown),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, wfd, eop, wt;
        logic        mw;
        logic [3:0]  ad;
        logic [31:0] da;
        logic        rs, wrdy, bsy;
        logic [15:0] fs;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic en, input logic wfd, input logic eop, input logic wt,
                                input logic mw, input logic [3:0] ad, input logic [31:0] da,
                                input logic rs, input logic wrdy, input logic bsy,
                                input logic [15:0] fs);
        vec_t v;
        v.en = en; v.wfd = wfd; v.eop = eop; v.wt = wt;
        v.mw = mw; v.ad = ad; v.da = da;
        v.rs = rs; v.wrdy = wrdy; v.bsy = bsy; v.fs = fs;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    initial begin
        // en wfd eop wt | mw ad da | rs wrdy busy fs
        tbl[0]  = mk(1,0,0,0, 0,4'h0,32'h0,      0,1,1,16'd0);
        tbl[1]  = mk(1,0,0,0, 1,4'h4,32'd1024,   0,1,1,16'd0);
        tbl[2]  = mk(1,0,0,0, 1,4'h0,32'h0,      0,1,1,16'd0);
        tbl[3]  = mk(1,0,0,0, 1,4'h8,32'h1,      0,1,1,16'd0);
        tbl[4]  = mk(1,0,0,0, 0,4'h0,32'h0,      0,1,1,16'd0);
        tbl[5]  = mk(1,1,0,0, 0,4'h0,32'h0,      0,0,1,16'd0);
        tbl[6]  = mk(1,0,1,0, 1,4'h0,32'h100000, 1,1,1,16'd1);
        tbl[7]  = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,1,16'd1);
        tbl[8]  = mk(1,0,1,0, 0,4'h0,32'h0,      1,1,1,16'd2);
        tbl[9]  = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,1,16'd2);
        tbl[10] = mk(1,0,1,0, 0,4'h0,32'h0,      1,1,1,16'd3);
        tbl[11] = mk(1,0,1,0, 0,4'h0,32'h0,      1,1,1,16'd4);
        tbl[12] = mk(1,1,1,0, 1,4'h0,32'h0,      0,1,1,16'd5);
        tbl[13] = mk(1,0,0,0, 0,4'h0,32'h0,      0,1,1,16'd5);
        tbl[14] = mk(1,1,0,0, 0,4'h0,32'h0,      0,0,1,16'd5);
        tbl[15] = mk(1,1,0,0, 0,4'h0,32'h0,      0,0,1,16'd5);
        tbl[16] = mk(1,0,1,0, 1,4'h0,32'h100000, 1,1,1,16'd6);
        for (int i = 17; i <= 21; i++) tbl[i] = mk(1,0,0,1, 1,4'h0,32'h100000, 1,1,1,16'd6);
        tbl[22] = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,1,16'd6);
        tbl[23] = mk(0,0,0,0, 1,4'h8,32'h0,      1,1,1,16'd6);
        tbl[24] = mk(0,0,0,0, 0,4'h0,32'h0,      1,1,0,16'd6);
        tbl[25] = mk(0,0,0,0, 0,4'h0,32'h0,      1,1,0,16'd6);
        tbl[26] = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,1,16'd6);
        tbl[27] = mk(1,0,0,1, 1,4'h4,32'd1024,   1,1,1,16'd6);
        tbl[28] = mk(0,0,0,1, 1,4'h4,32'd1024,   1,1,1,16'd6);
        tbl[29] = mk(0,0,0,0, 1,4'h8,32'h0,      1,1,1,16'd6);
        tbl[30] = mk(0,0,0,0, 0,4'h0,32'h0,      1,1,0,16'd6);
        tbl[31] = mk(0,0,0,0, 0,4'h0,32'h0,      1,1,0,16'd6);
        tbl[32] = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,1,16'd6);
        tbl[33] = mk(1,0,0,0, 1,4'h4,32'd1024,   1,1,1,16'd6);
        tbl[34] = mk(1,0,0,0, 1,4'h0,32'h100000, 1,1,1,16'd6);
        tbl[35] = mk(0,0,0,0, 1,4'h8,32'h0,      1,1,1,16'd6);
        tbl[36] = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,0,16'd6);
        tbl[37] = mk(1,0,0,0, 0,4'h0,32'h0,      1,1,1,16'd6);
        tbl[38] = mk(1,0,0,0, 1,4'h4,32'd1024,   1,1,1,16'd6);

        rst_n           = 1'b0;
        cfg_enable      = 1'b0;
        cfg_buf0_addr   = 24'h000000;
        cfg_buf1_addr   = 24'h100000;
        cfg_frame_words = 30'd1024;
        wr_frame_done   = 1'b0;
        st_valid        = 1'b0;
        st_ready        = 1'b0;
        st_endofpacket  = 1'b0;
        mm_waitrequest  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mm_write", 0, {31'd0, mm_write}, 32'd0);
        chk("rst_busy", 0, {31'd0, busy}, 32'd0);
        chk("rst_rd_sel", 0, {31'd0, rd_buf_sel}, 32'd0);
        chk("rst_wr_sel", 0, {31'd0, wr_buf_sel}, 32'd1);
        chk("rst_wr_ready", 0, {31'd0, wr_buf_ready}, 32'd1);
        chk("rst_byteen", 0, {28'd0, mm_byteenable}, 32'hF);
        chk("rst_frames", 0, {16'd0, frames_shown}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle-by-cycle vector table.
        for (int i = 0; i < NV; i++) begin
            cfg_enable     = tbl[i].en;
            wr_frame_done  = tbl[i].wfd;
            st_valid       = tbl[i].eop;
            st_ready       = tbl[i].eop;
            st_endofpacket = tbl[i].eop;
            mm_waitrequest = tbl[i].wt;
            @(posedge clk);
            #1;
            chk("mm_write", i, {31'd0, mm_write}, {31'd0, tbl[i].mw});
            if (tbl[i].mw) begin
                chk("mm_address", i, {28'd0, mm_address}, {28'd0, tbl[i].ad});
                chk("mm_writedata", i, mm_writedata, tbl[i].da);
            end
            chk("rd_buf_sel", i, {31'd0, rd_buf_sel}, {31'd0, tbl[i].rs});
            chk("wr_buf_sel", i, {31'd0, wr_buf_sel}, {31'd0, ~tbl[i].rs});
            chk("wr_buf_ready", i, {31'd0, wr_buf_ready}, {31'd0, tbl[i].wrdy});
            chk("busy", i, {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk("frames_shown", i, {16'd0, frames_shown}, {16'd0, tbl[i].fs});
            chk("err_timeout", i, {31'd0, err_timeout}, 32'd0);
        end
        wr_frame_done  = 1'b0;
        st_valid       = 1'b0;
        st_ready       = 1'b0;
        st_endofpacket = 1'b0;
        mm_waitrequest = 1'b0;

        // Asynchronous reset in the middle of a write.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mm_write", 0, {31'd0, mm_write}, 32'd0);
        chk("mid_rst_busy", 0, {31'd0, busy}, 32'd0);
        chk("mid_rst_rd_sel", 0, {31'd0, rd_buf_sel}, 32'd0);
        chk("mid_rst_wr_sel", 0, {31'd0, wr_buf_sel}, 32'd1);
        chk("mid_rst_frames", 0, {16'd0, frames_shown}, 32'd0);
        chk("mid_rst_data", 0, mm_writedata, 32'd0);

        // Restart from reset: programming sequence up to RUN.
        cfg_enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("restart_run_mw", 0, {31'd0, mm_write}, 32'd0);
        chk("restart_run_busy", 0, {31'd0, busy}, 32'd1);

`ifdef SEQ_FRAME_TIMEOUT_EN
        begin
            int n;
            n = 0;
            for (int k = 1; k <= 150; k++) begin
                @(posedge clk);
                #1;
                if (err_timeout && n == 0) n = k;
                if (n != 0) break;
            end
            chk("timeout_cycles", 0, n, 32'd100);
            chk("timeout_mw", 0, {31'd0, mm_write}, 32'd1);
            chk("timeout_addr", 0, {28'd0, mm_address}, 32'h0);
            chk("timeout_data", 0, mm_writedata, 32'h0);
            @(posedge clk);
            #1;
            chk("timeout_pulse_end", 0, {31'd0, err_timeout}, 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_frame_sequencer.md
Name: dma_frame_sequencer

Overview:
- Ping-pong frame-buffer controller for the AXI-read-to-stream DMA.
- Owns the DMA's Avalon-MM control port: programs word count, start address and enable, and swaps the read buffer at frame boundaries when the writer has completed a newer frame.
- Sits between the system config registers, the HDMI-side frame writer and the DMA control slave.

Parameters:
- ADDR_WIDTH, 24, width of buffer base addresses.
- CNT_WIDTH, 16, width of frames_shown counter.
- TIMEOUT_CYCLES, 24'hFFFFFF, watchdog limit in cycles; only used with SEQ_FRAME_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_enable  in  1  level; 1 = run display.
- cfg_buf0_addr  in  ADDR_WIDTH  byte base address of buffer 0.
- cfg_buf1_addr  in  ADDR_WIDTH  byte base address of buffer 1.
- cfg_frame_words  in  30  32-bit words per frame.
- wr_frame_done  in  1  one-cycle pulse: writer finished a frame in buffer wr_buf_sel.
- wr_buf_sel  out  1  buffer the writer must fill (always ~rd_buf_sel).
- wr_buf_ready  out  1  1 = writer may start a new frame.
- rd_buf_sel  out  1  buffer currently programmed into the DMA.
- st_valid, st_ready, st_endofpacket  in  1 each  monitored DMA stream handshake.
- mm_address  out  4  DMA control register address.
- mm_write  out  1  write strobe.
- mm_writedata  out  32  write data.
- mm_byteenable  out  4  constant 4'hF.
- mm_waitrequest  in  1  slave stall.
- busy  out  1  1 in any state other than IDLE.
- frames_shown  out  CNT_WIDTH  completed-frame counter.
- err_timeout  out  1  watchdog pulse (macro only; else tied 0).

Behaviour:
- Reset values: all outputs 0 except wr_buf_sel=1, wr_buf_ready=1, mm_byteenable=4'hF; state IDLE; pending=0.
- Avalon write rule: mm_address, mm_write and mm_writedata are registered and held stable until the cycle where mm_write && !mm_waitrequest; that cycle completes the write. mm_write deasserts the next cycle unless the next write follows back-to-back. Writes are never aborted.
- Register map: 0x0 start address ({8'b0, addr}), 0x4 words ({2'b0, words}), 0x8 enable (bit0).
- States:
  - IDLE: on cfg_enable=1 -> WR_WORDS.
  - WR_WORDS: write 0x4 = cfg_frame_words -> WR_ADDR.
  - WR_ADDR: write 0x0 = base of rd_buf_sel -> WR_EN if DMA disabled, else RUN.
  - WR_EN: write 0x8 = 1 -> RUN.
  - RUN: see swap rules below; on cfg_enable=0 -> WR_DIS.
  - WR_DIS: write 0x8 = 0 -> IDLE.
- Swap rules:
  - Frame end: st_valid && st_ready && st_endofpacket in RUN.
  - Frame end increments frames_shown (wraps at 2^CNT_WIDTH).
  - If pending=1 at frame end: toggle rd_buf_sel, clear pending, set wr_buf_ready=1, go to WR_ADDR.
- Writer handshake:
  - wr_frame_done sets pending=1 and clears wr_buf_ready.
  - wr_frame_done while pending=1: ignored; pending stays 1.
  - Same-cycle wr_frame_done and frame end with pending=0: pending is set first, so the swap occurs at this frame end.
- Enable/disable edge cases:
  - cfg_enable falling during WR_WORDS/WR_ADDR/WR_EN: the current write completes, then -> WR_DIS.
  - cfg_enable rising again during WR_DIS: completes WR_DIS, then IDLE -> WR_WORDS.
- cfg_* inputs are sampled when each write is launched; changes mid-RUN take effect at the next programming sequence.
- Reset mid-write: outputs drop to reset values immediately. The DMA has its own reset.
- Latency: cfg_enable rise to first mm_write = 2 cycles. With mm_waitrequest=0, each write takes 1 cycle.

Optional Feature:
- Macro: SEQ_FRAME_TIMEOUT_EN.
- Defined:
  - A 24-bit watchdog counts cycles in RUN and clears on each frame end and on leaving RUN.
  - On reaching TIMEOUT_CYCLES: pulse err_timeout for 1 cycle, clear the counter, go to WR_ADDR to re-write the current start address (DMA restart).
- Undefined: no counter; err_timeout tied 0.

Test Plan:
- Startup: buf0=0x000000, buf1=0x100000, words=1024, cfg_enable=1, no waitrequest -> writes (0x4,1024), (0x0,0x000000), (0x8,1) on consecutive cycles; busy=1; rd_buf_sel=0.
- Swap: wr_frame_done pulse then eop handshake -> write (0x0,0x100000); rd_buf_sel=1; wr_buf_sel=0; wr_buf_ready=1; frames_shown=1.
- No new frame: 3 eop handshakes without wr_frame_done -> no mm_write; frames_shown=3; rd_buf_sel unchanged.
- Waitrequest: mm_waitrequest held 5 cycles on the 0x0 write -> address/data stable for 6 cycles; single write completes.
- Disable during write: cfg_enable=0 while 0x4 is stalled -> 0x4 completes, then (0x8,0), then IDLE with busy=0; DMA enable is never written to 1.
- With SEQ_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100: no eop for 100 cycles in RUN -> err_timeout pulse, then rewrite (0x0, current base).
